next_addr_ctl: RTL and testbench
================================

NEXT_ADDR_CTL -- requirements
Module: next_addr_ctl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, loop-counter width in bits.
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port uop, input, 4, next-address opcode from the microinstruction pipeline register.
REQ-005 SHALL have port test, input, 1, selected condition; 1 = pass.
REQ-006 SHALL have port hold, input, 1, 1 = freeze sequencing this cycle.
REQ-007 SHALL have port cnt_din, input, CNT_W, loop-count load value from the pipeline-register data field.
REQ-008 SHALL have ports s1 and s0, output, 1 each, slice address-source select: 00 PC, 01 AR, 10 stack, 11 D.
REQ-009 SHALL have ports zero_n, fe_n, pup, re_n and cin, output, 1 each, driving the sequencer-slice controls of the same names.
REQ-010 SHALL have ports map_en_n, pl_en_n and vect_en_n, output, 1 each, active-low D-bus source enables: mapping PROM, pipeline register, vector.
REQ-011 SHALL have port cnt_zero, output, 1, 1 when the loop counter equals 0.

Function
REQ-012 SHALL make all outputs combinational from uop, test, hold, the counter and the reset-state flag; the loop counter and reset-state flag are the only state.
REQ-013 SHALL use these defaults unless an opcode overrides: zero_n=1, fe_n=1, pup=0, re_n=1, cin=1, pl_en_n=0, map_en_n=1, vect_en_n=1, sel=PC; "push" = fe_n=0,pup=1; "pop" = fe_n=0,pup=0; "dec" = counter-1 at clock edge; "load" = counter<=cnt_din at clock edge.
REQ-014 SHALL decode 0 JZ: zero_n=0 (address 0).
REQ-015 SHALL decode 1 CJS: pass: sel=D, push; fail: sel=PC.
REQ-016 SHALL decode 2 JMAP: sel=D, map_en_n=0, pl_en_n=1.
REQ-017 SHALL decode 3 CJP: pass: sel=D; fail: sel=PC.
REQ-018 SHALL decode 4 PUSH: sel=PC, push; load on pass.
REQ-019 SHALL decode 5 JSRP: sel=D on pass else AR, push.
REQ-020 SHALL decode 6 CJV: pass: sel=D, vect_en_n=0, pl_en_n=1; fail: sel=PC.
REQ-021 SHALL decode 7 JRP: sel=D on pass else AR.
REQ-022 SHALL decode 8 RFCT: counter!=0: sel=stack, dec; counter==0: sel=PC, pop.
REQ-023 SHALL decode 9 RPCT: counter!=0: sel=D, dec; counter==0: sel=PC.
REQ-024 SHALL decode A CRTN: pass: sel=stack, pop; fail: sel=PC.
REQ-025 SHALL decode B CJPP: pass: sel=D, pop; fail: sel=PC.
REQ-026 SHALL decode C LDCT: sel=PC, load, re_n=0.
REQ-027 SHALL decode D LOOP: pass: sel=PC, pop; fail: sel=stack.
REQ-028 SHALL decode E CONT: sel=PC.
REQ-029 SHALL decode F TWB, counter!=0: pass: sel=PC, pop; fail: sel=stack, dec. Counter==0: pass: sel=PC, pop; fail: sel=D, pop.
REQ-030 SHALL never decrement a zero counter; no wrap-around.
REQ-031 SHALL, on hold=1, force cin=0, sel=PC, fe_n=1, re_n=1, and suppress load and dec, so the slice PC re-presents the same address.
REQ-032 SHALL, when load and dec coincide (impossible by decode), give load priority.
REQ-033 SHALL give the counter result one-cycle latency: cnt_zero reflects the value after the edge.

Reset
REQ-034 SHALL, while reset=1, force JZ outputs with fe_n=1 and re_n=1, and clear the counter to 0 at the edge.
REQ-035 SHALL, in the first cycle after reset deasserts, still force JZ (pipeline register not yet valid) via a reset-state flag, then decode uop normally.
REQ-036 SHALL let reset mid-loop abandon the count: counter=0 and no stack push or pop during reset.

Structure
REQ-037 SHALL place opcode constants (JZ..TWB) and sel encodings in shared package usequ_pkg.
REQ-038 SHALL implement the counter as sub-module loop_counter (load, dec, zero flag); the decode SHALL stay in next_addr_ctl.

Verification
REQ-039 SHALL cover: reset 2 cycles, uop=E -> zero_n=0 in both reset cycles and in the first cycle after release; sel=PC, cin=1 from the next cycle.
REQ-040 SHALL cover: LDCT cnt_din=3, then RFCT x4 -> sel=stack for 3 cycles with counter 2,1,0; 4th: sel=PC, fe_n=0, pup=0.
REQ-041 SHALL cover: CJS test=1 -> s1s0=11, fe_n=0, pup=1; with test=0 -> s1s0=00, fe_n=1.
REQ-042 SHALL cover: TWB counter=0, test=0 -> s1s0=11, pop, counter stays 0.
REQ-043 SHALL cover: hold=1 during RPCT counter=5 -> cin=0, sel=PC, counter stays 5.
REQ-044 SHALL cover: JMAP -> map_en_n=0, pl_en_n=1; CJV test=1 -> vect_en_n=0, pl_en_n=1.

Source files
------------

// File: rtl/usequ_pkg.sv
// Shared definitions for the microsequencer next-address controller:
// opcode set, slice address-source encodings and the decoded control bundle.
package usequ_pkg;

    typedef enum logic [3:0] {
        UOP_JZ   = 4'h0,
        UOP_CJS  = 4'h1,
        UOP_JMAP = 4'h2,
        UOP_CJP  = 4'h3,
        UOP_PUSH = 4'h4,
        UOP_JSRP = 4'h5,
        UOP_CJV  = 4'h6,
        UOP_JRP  = 4'h7,
        UOP_RFCT = 4'h8,
        UOP_RPCT = 4'h9,
        UOP_CRTN = 4'hA,
        UOP_CJPP = 4'hB,
        UOP_LDCT = 4'hC,
        UOP_LOOP = 4'hD,
        UOP_CONT = 4'hE,
        UOP_TWB  = 4'hF
    } uop_e;

    typedef enum logic [1:0] {
        SEL_PC  = 2'b00,
        SEL_AR  = 2'b01,
        SEL_STK = 2'b10,
        SEL_D   = 2'b11
    } sel_e;

    typedef struct packed {
        sel_e sel;
        logic zero_n;
        logic fe_n;
        logic pup;
        logic re_n;
        logic cin;
        logic map_en_n;
        logic pl_en_n;
        logic vect_en_n;
        logic load;
        logic dec;
    } ctl_t;

    localparam ctl_t CTL_DEFAULT = '{
        sel:       SEL_PC,
        zero_n:    1'b1,
        fe_n:      1'b1,
        pup:       1'b0,
        re_n:      1'b1,
        cin:       1'b1,
        map_en_n:  1'b1,
        pl_en_n:   1'b0,
        vect_en_n: 1'b1,
        load:      1'b0,
        dec:       1'b0
    };

    function automatic ctl_t ctl_push(input ctl_t c);
        ctl_t r;
        r      = c;
        r.fe_n = 1'b0;
        r.pup  = 1'b1;
        return r;
    endfunction

    function automatic ctl_t ctl_pop(input ctl_t c);
        ctl_t r;
        r      = c;
        r.fe_n = 1'b0;
        r.pup  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Loop counter for repeat/loop microinstructions; load wins over decrement
// and the count saturates at zero instead of wrapping.
module loop_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: reset clears, load has priority, decrement stops at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= din;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == '0);

endmodule

// File: rtl/next_addr_ctl.sv
// Next-address control for a bit-slice microsequencer: decodes the 4-bit
// next-address opcode into slice controls and drives the loop counter.
module next_addr_ctl
    import usequ_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       uop,
    input  logic             test,
    input  logic             hold,
    input  logic [CNT_W-1:0] cnt_din,
    output logic             s1,
    output logic             s0,
    output logic             zero_n,
    output logic             fe_n,
    output logic             pup,
    output logic             re_n,
    output logic             cin,
    output logic             map_en_n,
    output logic             pl_en_n,
    output logic             vect_en_n,
    output logic             cnt_zero
);

    logic             rst_state_r;
    logic             cnt_zero_s;
    logic [CNT_W-1:0] count_s;
    ctl_t             dec_s;
    ctl_t             ctl_s;

    // Pipeline register is not valid until one cycle after reset releases
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_state_r <= 1'b1;
        end else begin
            rst_state_r <= 1'b0;
        end
    end

    // Opcode decode
    always_comb begin
        dec_s = CTL_DEFAULT;
        case (uop_e'(uop))
            UOP_JZ:   dec_s.zero_n = 1'b0;
            UOP_CJS:  begin
                if (test) begin
                    dec_s.sel = SEL_D;
                    dec_s     = ctl_push(dec_s);
                end else begin
                    dec_s.sel = SEL_PC;
                end
            end
            UOP_JMAP: begin
                dec_s.sel      = SEL_D;
                dec_s.map_en_n = 1'b0;
                dec_s.pl_en_n  = 1'b1;
            end
            UOP_CJP:  dec_s.sel = test ? SEL_D : SEL_PC;
            UOP_PUSH: begin
                dec_s.sel  = SEL_PC;
                dec_s      = ctl_push(dec_s);
                dec_s.load = test;
            end
            UOP_JSRP: begin
                dec_s.sel = test ? SEL_D : SEL_AR;
                dec_s     = ctl_push(dec_s);
            end
            UOP_CJV:  begin
                if (test) begin
                    dec_s.sel       = SEL_D;
                    dec_s.vect_en_n = 1'b0;
                    dec_s.pl_en_n   = 1'b1;
                end else begin
                    dec_s.sel = SEL_PC;
                end
            end
            UOP_JRP:  dec_s.sel = test ? SEL_D : SEL_AR;
            UOP_RFCT: begin
                if (!cnt_zero_s) begin
                    dec_s.sel = SEL_STK;
                    dec_s.dec = 1'b1;
                end else begin
                    dec_s.sel = SEL_PC;
                    dec_s     = ctl_pop(dec_s);
                end
            end
            UOP_RPCT: begin
                if (!cnt_zero_s) begin
                    dec_s.sel = SEL_D;
                    dec_s.dec = 1'b1;
                end else begin
                    dec_s.sel = SEL_PC;
                end
            end
            UOP_CRTN: begin
                if (test) begin
                    dec_s.sel = SEL_STK;
                    dec_s     = ctl_pop(dec_s);
                end else begin
                    dec_s.sel = SEL_PC;
                end
            end
            UOP_CJPP: begin
                if (test) begin
                    dec_s.sel = SEL_D;
                    dec_s     = ctl_pop(dec_s);
                end else begin
                    dec_s.sel = SEL_PC;
                end
            end
            UOP_LDCT: begin
                dec_s.sel  = SEL_PC;
                dec_s.load = 1'b1;
                dec_s.re_n = 1'b0;
            end
            UOP_LOOP: begin
                if (test) begin
                    dec_s.sel = SEL_PC;
                    dec_s     = ctl_pop(dec_s);
                end else begin
                    dec_s.sel = SEL_STK;
                end
            end
            UOP_CONT: dec_s.sel = SEL_PC;
            UOP_TWB:  begin
                if (test) begin
                    dec_s.sel = SEL_PC;
                    dec_s     = ctl_pop(dec_s);
                end else if (!cnt_zero_s) begin
                    dec_s.sel = SEL_STK;
                    dec_s.dec = 1'b1;
                end else begin
                    dec_s.sel = SEL_D;
                    dec_s     = ctl_pop(dec_s);
                end
            end
            default:  dec_s = CTL_DEFAULT;
        endcase
    end

    // Reset and hold overrides; under hold zero_n is also released so the
    // incremented-then-held PC really re-presents the same address
    always_comb begin
        ctl_s = dec_s;
        if (reset || rst_state_r) begin
            ctl_s        = CTL_DEFAULT;
            ctl_s.zero_n = 1'b0;
        end else if (hold) begin
            ctl_s.sel    = SEL_PC;
            ctl_s.cin    = 1'b0;
            ctl_s.fe_n   = 1'b1;
            ctl_s.pup    = 1'b0;
            ctl_s.re_n   = 1'b1;
            ctl_s.zero_n = 1'b1;
            ctl_s.load   = 1'b0;
            ctl_s.dec    = 1'b0;
        end else begin
            ctl_s = dec_s;
        end
    end

    loop_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (ctl_s.load),
        .dec   (ctl_s.dec),
        .din   (cnt_din),
        .count (count_s),
        .zero  (cnt_zero_s)
    );

    assign s1        = ctl_s.sel[1];
    assign s0        = ctl_s.sel[0];
    assign zero_n    = ctl_s.zero_n;
    assign fe_n      = ctl_s.fe_n;
    assign pup       = ctl_s.pup;
    assign re_n      = ctl_s.re_n;
    assign cin       = ctl_s.cin;
    assign map_en_n  = ctl_s.map_en_n;
    assign pl_en_n   = ctl_s.pl_en_n;
    assign vect_en_n = ctl_s.vect_en_n;
    assign cnt_zero  = cnt_zero_s;

endmodule

// File: tb/tb_next_addr_ctl.sv
// Directed bench for next_addr_ctl: each step drives one microinstruction,
// checks the combinational controls mid-cycle, then the counter after the edge.
module tb_next_addr_ctl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] uop;
    logic       test;
    logic       hold;
    logic [7:0] cnt_din;
    logic       s1, s0, zero_n, fe_n, pup, re_n, cin;
    logic       map_en_n, pl_en_n, vect_en_n, cnt_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    next_addr_ctl #(.CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .uop       (uop),
        .test      (test),
        .hold      (hold),
        .cnt_din   (cnt_din),
        .s1        (s1),
        .s0        (s0),
        .zero_n    (zero_n),
        .fe_n      (fe_n),
        .pup       (pup),
        .re_n      (re_n),
        .cin       (cin),
        .map_en_n  (map_en_n),
        .pl_en_n   (pl_en_n),
        .vect_en_n (vect_en_n),
        .cnt_zero  (cnt_zero)
    );

    // Observed control vector: {s1,s0,zero_n,fe_n,pup,re_n,cin,map_en_n,pl_en_n,vect_en_n}
    logic [9:0] outs;
    assign outs = {s1, s0, zero_n, fe_n, pup, re_n, cin, map_en_n, pl_en_n, vect_en_n};

    function automatic logic [9:0] ctl(input logic [1:0] sel, input logic zn, input logic fe,
                                       input logic pu, input logic re, input logic ci,
                                       input logic mp, input logic pl, input logic ve);
        return {sel, zn, fe, pu, re, ci, mp, pl, ve};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check controls, clock edge, check counter state
    task automatic cyc(input string tag, input logic [3:0] u, input logic t, input logic h,
                       input logic [7:0] din, input logic [9:0] exp_out, input logic [7:0] exp_cnt);
        uop     = u;
        test    = t;
        hold    = h;
        cnt_din = din;
        #1;
        chk({tag, "_out"}, {22'd0, outs}, {22'd0, exp_out});
        @(posedge clock);
        #1;
        chk({tag, "_cnt"}, {23'd0, cnt_zero, dut.u_cnt.count},
            {23'd0, (exp_cnt == 8'd0), exp_cnt});
    endtask

    logic [9:0] v_jz, v_cont, v_ldct, v_stk, v_pc_pop, v_d, v_d_push, v_d_pop;
    logic [9:0] v_pc_push, v_ar, v_ar_push, v_stk_pop, v_hold, v_map, v_vect;

    initial begin
        v_jz      = ctl(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_cont    = ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_ldct    = ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        v_stk     = ctl(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_stk_pop = ctl(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_pc_pop  = ctl(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_pc_push = ctl(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_d       = ctl(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_d_push  = ctl(2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_d_pop   = ctl(2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_ar      = ctl(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_ar_push = ctl(2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        v_hold    = ctl(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        v_map     = ctl(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        v_vect    = ctl(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Two reset cycles plus the pipeline-not-valid cycle all present JZ
        reset = 1'b1;
        cyc("rst0",      4'hE, 1'b0, 1'b0, 8'd0, v_jz,   8'd0);
        cyc("rst1",      4'hE, 1'b0, 1'b0, 8'd0, v_jz,   8'd0);
        reset = 1'b0;
        cyc("rst_flag",  4'hE, 1'b0, 1'b0, 8'd0, v_jz,   8'd0);
        cyc("cont",      4'hE, 1'b0, 1'b0, 8'd0, v_cont, 8'd0);

        // LDCT 3 then RFCT x4
        cyc("ldct3",     4'hC, 1'b0, 1'b0, 8'd3, v_ldct,   8'd3);
        cyc("rfct_a",    4'h8, 1'b0, 1'b0, 8'd0, v_stk,    8'd2);
        cyc("rfct_b",    4'h8, 1'b0, 1'b0, 8'd0, v_stk,    8'd1);
        cyc("rfct_c",    4'h8, 1'b0, 1'b0, 8'd0, v_stk,    8'd0);
        cyc("rfct_end",  4'h8, 1'b0, 1'b0, 8'd0, v_pc_pop, 8'd0);

        cyc("cjs_pass",  4'h1, 1'b1, 1'b0, 8'd0, v_d_push, 8'd0);
        cyc("cjs_fail",  4'h1, 1'b0, 1'b0, 8'd0, v_cont,   8'd0);

        // TWB at both counter states
        cyc("twb_z_f",   4'hF, 1'b0, 1'b0, 8'd0, v_d_pop,  8'd0);
        cyc("ldct2",     4'hC, 1'b0, 1'b0, 8'd2, v_ldct,   8'd2);
        cyc("twb_nz_f",  4'hF, 1'b0, 1'b0, 8'd0, v_stk,    8'd1);
        cyc("twb_nz_p",  4'hF, 1'b1, 1'b0, 8'd0, v_pc_pop, 8'd1);
        cyc("twb_z_p0",  4'h9, 1'b0, 1'b0, 8'd0, v_d,      8'd0);
        cyc("twb_z_p",   4'hF, 1'b1, 1'b0, 8'd0, v_pc_pop, 8'd0);

        // RPCT at zero never wraps
        cyc("rpct_z",    4'h9, 1'b0, 1'b0, 8'd0, v_cont,   8'd0);

        // Hold during RPCT freezes sequencing and the counter
        cyc("ldct5",     4'hC, 1'b0, 1'b0, 8'd5, v_ldct,   8'd5);
        cyc("rpct_hold", 4'h9, 1'b0, 1'b1, 8'd0, v_hold,   8'd5);
        cyc("rpct_run",  4'h9, 1'b0, 1'b0, 8'd0, v_d,      8'd4);
        cyc("ldct_hold", 4'hC, 1'b0, 1'b1, 8'd9, v_hold,   8'd4);

        cyc("jmap",      4'h2, 1'b0, 1'b0, 8'd0, v_map,    8'd4);
        cyc("cjv_pass",  4'h6, 1'b1, 1'b0, 8'd0, v_vect,   8'd4);
        cyc("cjv_fail",  4'h6, 1'b0, 1'b0, 8'd0, v_cont,   8'd4);
        cyc("jz",        4'h0, 1'b1, 1'b0, 8'd0, v_jz,     8'd4);
        cyc("cjp_pass",  4'h3, 1'b1, 1'b0, 8'd0, v_d,      8'd4);
        cyc("cjp_fail",  4'h3, 1'b0, 1'b0, 8'd0, v_cont,   8'd4);
        cyc("push_pass", 4'h4, 1'b1, 1'b0, 8'd7, v_pc_push, 8'd7);
        cyc("push_fail", 4'h4, 1'b0, 1'b0, 8'd9, v_pc_push, 8'd7);
        cyc("jsrp_pass", 4'h5, 1'b1, 1'b0, 8'd0, v_d_push,  8'd7);
        cyc("jsrp_fail", 4'h5, 1'b0, 1'b0, 8'd0, v_ar_push, 8'd7);
        cyc("jrp_pass",  4'h7, 1'b1, 1'b0, 8'd0, v_d,       8'd7);
        cyc("jrp_fail",  4'h7, 1'b0, 1'b0, 8'd0, v_ar,      8'd7);
        cyc("crtn_pass", 4'hA, 1'b1, 1'b0, 8'd0, v_stk_pop, 8'd7);
        cyc("crtn_fail", 4'hA, 1'b0, 1'b0, 8'd0, v_cont,    8'd7);
        cyc("cjpp_pass", 4'hB, 1'b1, 1'b0, 8'd0, v_d_pop,   8'd7);
        cyc("cjpp_fail", 4'hB, 1'b0, 1'b0, 8'd0, v_cont,    8'd7);
        cyc("loop_fail", 4'hD, 1'b0, 1'b0, 8'd0, v_stk,     8'd7);
        cyc("loop_pass", 4'hD, 1'b1, 1'b0, 8'd0, v_pc_pop,  8'd7);

        // Reset mid-loop abandons the count; no load in the flag cycle
        reset = 1'b1;
        cyc("mid_rst",   4'h8, 1'b0, 1'b0, 8'd0, v_jz,     8'd0);
        reset = 1'b0;
        cyc("mid_flag",  4'hC, 1'b0, 1'b0, 8'd4, v_jz,     8'd0);
        cyc("post_ldct", 4'hC, 1'b0, 1'b0, 8'd4, v_ldct,   8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
